// File: rtl/rca_seq_pkg.sv
// rtl/rca_seq_pkg.sv - shared types and defaults for the sequential ripple-carry add controller
package rca_seq_pkg;

   localparam int CHUNK_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational W-bit ripple-carry adder built from full-adder cells
module rca_slice
   import rca_seq_pkg::*;
#(
   parameter int W = CHUNK_W_DEF
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_s,
   output logic         o_cout
);

   logic [W:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign o_s[gi]     = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
   end

   assign o_cout = w_c[W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - two-requester add controller sharing one ripple-carry slice
// RCA_SEQ_SUBTRACT_EN adds req0_sub/req1_sub for A-B requests.
module rca_seq_ctrl
   import rca_seq_pkg::*;
#(
   parameter int OP_W    = 16,
   parameter int CHUNK_W = CHUNK_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OP_W-1:0] req0_a,
   input  logic [OP_W-1:0] req0_b,
`ifdef RCA_SEQ_SUBTRACT_EN
   input  logic            req0_sub,
`endif
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OP_W-1:0] req1_a,
   input  logic [OP_W-1:0] req1_b,
`ifdef RCA_SEQ_SUBTRACT_EN
   input  logic            req1_sub,
`endif
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [OP_W-1:0] rsp_sum,
   output logic            rsp_cout
);

   localparam int N     = OP_W / CHUNK_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   if ((OP_W % CHUNK_W) != 0 || OP_W < CHUNK_W) begin : g_bad_width
      $error("rca_seq_ctrl: OP_W must be an integer multiple of CHUNK_W");
   end

   state_t             r_state;
   state_t             w_next_state;
   logic [OP_W-1:0]    r_a;
   logic [OP_W-1:0]    r_b;
   logic [OP_W-1:0]    r_sum;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_id;
   logic               r_cout;
   logic               r_ptr;

   logic               w_grant;
   logic               w_accept;
   logic               w_last;
   logic               w_cin_init;
   logic [CHUNK_W-1:0] w_a_slice;
   logic [CHUNK_W-1:0] w_b_slice;
   logic [CHUNK_W-1:0] w_s;
   logic               w_cout;

`ifdef RCA_SEQ_SUBTRACT_EN
   logic               r_sub;

   // Subtraction is A + ~B + 1: invert the B slice and seed the carry with 1.
   assign w_cin_init = w_grant ? req1_sub : req0_sub;
   assign w_b_slice  = r_b[r_cnt*CHUNK_W +: CHUNK_W] ^ {CHUNK_W{r_sub}};
`else
   assign w_cin_init = 1'b0;
   assign w_b_slice  = r_b[r_cnt*CHUNK_W +: CHUNK_W];
`endif

   assign w_a_slice = r_a[r_cnt*CHUNK_W +: CHUNK_W];
   assign w_last    = (r_cnt == CNT_W'(N - 1));
   assign w_accept  = req0_ready | req1_ready;

   rca_slice #(
      .W (CHUNK_W)
   ) u_slice (
      .i_a    (w_a_slice),
      .i_b    (w_b_slice),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_cout)
   );

   // Lone valid requester wins; on contention the pointer decides.
   always_comb begin
      w_grant      = r_ptr;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      w_next_state = r_state;
      if (req0_valid && !req1_valid) begin
         w_grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         w_grant = 1'b1;
      end
      case (r_state)
         IDLE: begin
            req0_ready = req0_valid & ~w_grant;
            req1_ready = req1_valid & w_grant;
            if ((req0_valid & ~w_grant) | (req1_valid & w_grant)) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_id    <= 1'b0;
         r_cout  <= 1'b0;
         r_ptr   <= 1'b0;
`ifdef RCA_SEQ_SUBTRACT_EN
         r_sub   <= 1'b0;
`endif
      end else begin
         r_state <= w_next_state;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a     <= w_grant ? req1_a : req0_a;
                  r_b     <= w_grant ? req1_b : req0_b;
                  r_id    <= w_grant;
                  r_carry <= w_cin_init;
                  r_cnt   <= '0;
`ifdef RCA_SEQ_SUBTRACT_EN
                  r_sub   <= w_cin_init;
`endif
               end
            end
            RUN: begin
               r_sum[r_cnt*CHUNK_W +: CHUNK_W] <= w_s;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_cout <= w_cout;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  r_ptr <= ~r_id;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (r_state == DONE);
   assign rsp_id    = r_id;
   assign rsp_sum   = r_sum;
   assign rsp_cout  = r_cout;

endmodule
